// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
// FSM state encoding, register map offsets, STATUS bit layout and default
// baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Register map (only address bit 0 is decoded)
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS register layout
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous FIFO feeding the transmitter.
// Pushes into a full FIFO are dropped even when a pop happens on the same
// edge; DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped UART transmitter with a transmit FIFO.
// DATA (addr bit0=0) write queues a byte; STATUS (addr bit0=1) reads
// empty/full/busy/overflow/count and a write of bit0=1 clears overflow.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1);
// without it frames are 8N1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MW_i,
    input  logic        MR_i,
    input  logic [9:0]  address_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx,
    output logic        tx_led
);

    localparam int             BCW      = $clog2(CLKS_PER_BIT);
    localparam int             FCW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);

    uart_state_t    r_state, w_state_nxt;
    logic [BCW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic [2:0]     r_bitidx, w_bitidx_nxt;
    logic           r_tx, w_tx_nxt;
    logic           r_overflow;
    logic           w_pop;
    logic           w_bit_done;
    logic           w_push;
    logic           w_clr_ovf;
    logic           w_busy;
    logic [7:0]     w_fifo_data;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [FCW-1:0] w_fifo_count;
    logic           w_unused_bits;
`ifdef UART_TX_PARITY_EN
    logic           r_parity, w_parity_nxt;
`endif

    assign w_push        = MW_i && (address_i[0] == REG_DATA);
    assign w_clr_ovf     = MW_i && (address_i[0] == REG_STATUS) && data_i[0];
    assign w_bit_done    = (r_cnt == '0);
    assign w_busy        = (r_state != ST_IDLE) || !w_fifo_empty;
    assign w_unused_bits = ^{address_i[9:1], data_i[31:8]};
    assign tx            = r_tx;
    assign tx_led        = w_busy;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (data_i[7:0]),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // State register plus frame datapath; tx is registered from next-state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_bitidx <= '0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_bitidx <= w_bitidx_nxt;
            r_tx     <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    // Next-state logic: bit counter reloads on every state or bit change
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt - BCW'(1);
        w_shift_nxt  = r_shift;
        w_bitidx_nxt = r_bitidx;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_fifo_data;
                    w_bitidx_nxt = '0;
                    w_cnt_nxt    = BIT_LAST;
                    w_state_nxt  = ST_START;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^w_fifo_data;
`endif
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = BIT_LAST;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = BIT_LAST;
                    if (r_bitidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bitidx_nxt = r_bitidx + 3'd1;
                        w_shift_nxt  = {1'b0, r_shift[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = BIT_LAST;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level for the cycle after the edge, derived from next-state values
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    // Sticky overflow: set on a dropped DATA write, cleared by STATUS bit0
    always_ff @(posedge clk) begin
        if (reset)                         r_overflow <= 1'b0;
        else if (w_push && w_fifo_full)    r_overflow <= 1'b1;
        else if (w_clr_ovf)                r_overflow <= 1'b0;
    end

    // Combinational read mux; only STATUS returns data
    always_comb begin
        data_o = '0;
        if (MR_i && (address_i[0] == REG_STATUS)) begin
            data_o[STAT_EMPTY]             = w_fifo_empty;
            data_o[STAT_FULL]              = w_fifo_full;
            data_o[STAT_BUSY]              = w_busy;
            data_o[STAT_OVF]               = r_overflow;
            data_o[STAT_CNT_LSB +: FCW]    = w_fifo_count;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=4). Frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB    = 11;
`else
    localparam int FB    = 10;
`endif
    localparam int FL    = FB * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        MW_i;
    logic        MR_i;
    logic [9:0]  address_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx;
    logic        tx_led;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MW_i      (MW_i),
        .MR_i      (MR_i),
        .address_i (address_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .tx        (tx),
        .tx_led    (tx_led)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        MW_i      = 1'b1;
        address_i = {9'd0, a};
        data_i    = d;
        tick();
        MW_i      = 1'b0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        MR_i      = 1'b1;
        address_i = 10'd1;
        #1;
        v         = data_o;
        MR_i      = 1'b0;
    endtask

    // Expected line level i cycles into a frame carrying byte d
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int b;
        b = i / CPB;
        if (b == 0)                 return 1'b0;
        if (b <= 8)                 return d[b-1];
        if (FB == 11 && b == 9)     return ^d;
        return 1'b1;
    endfunction

    // Follows one whole frame cycle by cycle; any pending write is taken
    // on the first edge and then released.
    task automatic expect_frame(input logic [7:0] d);
        for (int i = 0; i < FL; i++) begin
            tick();
            MW_i = 1'b0;
            chk($sformatf("frame_%02h_tx_c%0d", d, i), {31'd0, tx}, {31'd0, exp_bit(d, i)});
            chk($sformatf("frame_%02h_led_c%0d", d, i), {31'd0, tx_led}, 32'd1);
        end
    endtask

    logic [31:0] st;
    int          n;

    initial begin
        reset     = 1'b1;
        MW_i      = 1'b0;
        MR_i      = 1'b0;
        address_i = '0;
        data_i    = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_led", {31'd0, tx_led}, 32'd0);
        rd_status(st);
        chk("reset_status", st, 32'h001);
        address_i = 10'd1;
        MR_i      = 1'b0;
        #1 chk("no_read_data_o", data_o, 32'h0);
        MR_i      = 1'b1;
        address_i = 10'd0;
        #1 chk("read_data_addr", data_o, 32'h0);
        MR_i      = 1'b0;

        // 0x55: line stays high on the write edge, falls one edge later
        wr(1'b0, 32'h0000_0055);
        chk("lat_tx_high", {31'd0, tx}, 32'd1);
        chk("lat_led", {31'd0, tx_led}, 32'd1);
        expect_frame(8'h55);
        tick();
        chk("55_end_tx", {31'd0, tx}, 32'd1);
        chk("55_end_led", {31'd0, tx_led}, 32'd0);

        // 0xA3: parity 0 when enabled; frame length checked via tx_led
        wr(1'b0, 32'h0000_00A3);
        expect_frame(8'hA3);
        tick();
        chk("a3_end_led", {31'd0, tx_led}, 32'd0);
        chk("a3_end_tx", {31'd0, tx}, 32'd1);

        // Six consecutive writes: one pops, four fill, sixth dropped
        MW_i      = 1'b1;
        address_i = 10'd0;
        for (int k = 0; k < 6; k++) begin
            data_i = 32'h10 + k;
            tick();
        end
        MW_i = 1'b0;
        rd_status(st);
        chk("ovf_status", st, 32'h40E);
        wr(1'b1, 32'hFFFF_FFFE);
        rd_status(st);
        chk("ovf_no_clear", st, 32'h40E);
        wr(1'b1, 32'h0000_0001);
        rd_status(st);
        chk("ovf_cleared", st, 32'h406);
        n = 0;
        while (tx_led && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_in_time", {31'd0, n < 2000}, 32'd1);
        rd_status(st);
        chk("drain_status", st, 32'h001);
        tick();

        // Back-to-back 0x01, 0x02 with exactly one idle cycle between
        MW_i      = 1'b1;
        address_i = 10'd0;
        data_i    = 32'h01;
        tick();
        data_i    = 32'h02;
        expect_frame(8'h01);
        tick();
        chk("gap_tx", {31'd0, tx}, 32'd1);
        chk("gap_led", {31'd0, tx_led}, 32'd1);
        expect_frame(8'h02);
        tick();
        rd_status(st);
        chk("b2b_status", st, 32'h001);

        // Reset in DATA bit 3 with two bytes queued
        MW_i      = 1'b1;
        address_i = 10'd0;
        data_i    = 32'hC5;
        tick();
        data_i    = 32'h11;
        tick();
        data_i    = 32'h22;
        tick();
        MW_i = 1'b0;
        repeat (16) tick();
        chk("mid_bit3_tx", {31'd0, tx}, 32'd0);
        rd_status(st);
        chk("mid_status", st, 32'h204);
        reset     = 1'b1;
        MW_i      = 1'b1;
        address_i = 10'd0;
        data_i    = 32'h77;
        tick();
        reset = 1'b0;
        MW_i  = 1'b0;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_led", {31'd0, tx_led}, 32'd0);
        rd_status(st);
        chk("rst_status", st, 32'h001);
        for (int k = 0; k < 60; k++) begin
            tick();
            chk($sformatf("post_rst_idle_c%0d", k), {31'd0, tx}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
